alu_sequencer: RTL and testbench

Command-side initiator for the 8-bit registered ALU. It accepts one operation at a time from a host over a valid/ready command channel and drives the ALU operand, opcode and clear pins. It waits out the ALU's pipeline latency, captures result and carry, and returns them on a valid/ready response channel. An 8-bit accumulator lets consecutive commands chain on the previous result.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_sequencer.sv | 115 +++++++++++
 tb/tb_alu_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the ALU command sequencer.
// Opcodes, FSM state encoding and the divide-by-zero helper.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NAND = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_XNOR = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_ROR  = 4'd14;
  localparam logic [3:0] OP_ROL  = 4'd15;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic is_div_zero(
    input logic [3:0] op,
    input logic       b_zero
  );
    return (op == OP_DIV) && b_zero;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time command initiator for the registered ALU.
// Ports: cmd_* host command in, rsp_* response out, alu_* ALU pins, acc.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                clk,
  input  logic                en_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPC_W-1:0]    cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic                cmd_use_acc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_y,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   acc,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OPC_W-1:0]    alu_s,
  output logic                alu_en,
  input  logic [2*DATA_W-1:0] alu_y,
  input  logic                alu_carry
);

  localparam int CNT_W =
    (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              hs;
  logic              div0;
  logic [DATA_W-1:0] eff_a;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign hs        = cmd_valid & cmd_ready;
  assign eff_a     = cmd_use_acc ? acc : cmd_a;
  assign div0      = is_div_zero(4'(cmd_op),
                                 cmd_b == '0);

  // INIT uses cnt as a one-cycle delay so alu_en
  // is sampled high by the ALU on the first edge
  // after reset release before dropping.
  always_ff @(posedge clk or negedge en_n) begin
    if (!en_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      alu_en    <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      rsp_y     <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      acc       <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (cnt == '0) begin
            cnt <= CNT_W'(1);
          end else begin
            cnt    <= '0;
            alu_en <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (hs) begin
            if (div0) begin
              rsp_y     <= '0;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_a <= eff_a;
              alu_b <= cmd_b;
              alu_s <= cmd_op;
              cnt   <= CNT_W'(ALU_LAT);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_y     <= alu_y;
            rsp_carry <= alu_carry;
            rsp_zero  <= (alu_y == '0);
            rsp_err   <= 1'b0;
            acc       <= alu_y[DATA_W-1:0];
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer
// driving a behavioural two-stage registered ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        en_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        cmd_use_acc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_y;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_err;
  logic [7:0]  acc;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_s;
  logic        alu_en;
  logic [15:0] alu_y;
  logic        alu_carry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        e;
    logic [7:0]  acc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_sequencer #(
    .DATA_W(8), .OPC_W(4), .ALU_LAT(2)
  ) dut (
    .clk(clk), .en_n(en_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .acc(acc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s(alu_s), .alu_en(alu_en),
    .alu_y(alu_y), .alu_carry(alu_carry)
  );

  // Behavioural ALU: operands registered on one edge,
  // result on the next; s is combinational into stage 2.
  function automatic logic [16:0] alu_f(
    input logic [7:0] a, input logic [7:0] b,
    input logic [3:0] s
  );
    logic [8:0] t;
    case (s)
      4'd0: begin t = {1'b0, a} + {1'b0, b};
        return {t[8], 8'h00, t[7:0]}; end
      4'd1: begin t = {1'b0, a} - {1'b0, b};
        return {t[8], 8'h00, t[7:0]}; end
      4'd2: begin t = {1'b0, a} + 9'd1;
        return {t[8], 8'h00, t[7:0]}; end
      4'd3: begin t = {1'b0, a} - 9'd1;
        return {t[8], 8'h00, t[7:0]}; end
      4'd4: return {1'b0, 16'(a) * 16'(b)};
      4'd5: return (b == 0) ? 17'd0
                            : {9'd0, a / b};
      4'd6:  return {9'd0, a & b};
      4'd7:  return {9'd0, a | b};
      4'd8:  return {9'd0, a ^ b};
      4'd9:  return {9'd0, ~(a & b)};
      4'd10: return {9'd0, ~(a | b)};
      4'd11: return {9'd0, ~(a ^ b)};
      4'd12: return {a[7], 8'h00, a[6:0], 1'b0};
      4'd13: return {a[0], 8'h00, 1'b0, a[7:1]};
      4'd14: return {a[0], 8'h00, a[0], a[7:1]};
      default: return {a[7], 8'h00, a[6:0], a[7]};
    endcase
  endfunction

  logic [7:0] ra, rb;
  always_ff @(posedge clk) begin
    if (alu_en) begin
      ra <= '0;
      rb <= '0;
      alu_y <= '0;
      alu_carry <= 1'b0;
    end else begin
      ra <= alu_a;
      rb <= alu_b;
      {alu_carry, alu_y} <= alu_f(ra, rb, alu_s);
    end
  end

  // lat: posedges after the handshake edge until
  // rsp_valid is seen (0 = set by the handshake edge).
  task automatic send(
    input logic [3:0] op, input logic [7:0] a,
    input logic [7:0] b, input logic ua,
    input logic [7:0] exp_a,
    input logic [15:0] y, input logic c,
    input logic e, input logic [7:0] eacc,
    input int lat
  );
    exp_t x;
    int n;
    bit busy_bad;
    x.y = y; x.c = c; x.z = (y == 0);
    x.e = e; x.acc = eacc;
    sb.push_back(x);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b want 1",
               cmd_ready);
    end
    cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_use_acc = ua; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    cmd_op = 4'($urandom);
    cmd_use_acc = 1'($urandom);
    if (!e) begin
      checks++;
      if (alu_a !== exp_a || alu_s !== op) begin
        errors++;
        $display("FAIL alu_pins a=%h s=%h want %h %h",
                 alu_a, alu_s, exp_a, op);
      end
    end
    n = 0;
    busy_bad = 0;
    while (!rsp_valid && n < 20) begin
      if (cmd_ready !== 1'b0) busy_bad = 1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || n != lat ||
        busy_bad) begin
      errors++;
      $display("FAIL latency v=%b n=%0d want %0d busy=%b",
               rsp_valid, n, lat, busy_bad);
    end
  endtask

  task automatic recv(input int hold);
    exp_t x;
    logic [19:0] snap;
    bit bad;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty no expected entry");
      return;
    end
    x = sb.pop_front();
    if (rsp_y !== x.y || rsp_carry !== x.c ||
        rsp_zero !== x.z || rsp_err !== x.e ||
        acc !== x.acc) begin
      errors++;
      $display("FAIL rsp y=%h c=%b z=%b e=%b acc=%h want %h %b %b %b %h",
               rsp_y, rsp_carry, rsp_zero, rsp_err,
               acc, x.y, x.c, x.z, x.e, x.acc);
    end
    snap = {rsp_y, rsp_carry, rsp_zero,
            rsp_err, rsp_valid};
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if ({rsp_y, rsp_carry, rsp_zero,
           rsp_err, rsp_valid} !== snap ||
          cmd_ready !== 1'b0) bad = 1;
    end
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL hold_stable y=%h v=%b rdy=%b want %h 1 0",
                 rsp_y, rsp_valid, cmd_ready,
                 snap[19:4]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_done v=%b rdy=%b want 0 1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (alu_en !== 1'b1 || cmd_ready !== 1'b0 ||
        rsp_valid !== 1'b0 || acc !== 8'h00 ||
        alu_a !== 8'h00 || alu_b !== 8'h00 ||
        alu_s !== 4'h0 || rsp_y !== 16'h0 ||
        rsp_err !== 1'b0 || rsp_zero !== 1'b0 ||
        rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL %s en=%b rdy=%b v=%b acc=%h a=%h s=%h y=%h want 1 0 0 00 00 0 0000",
               tag, alu_en, cmd_ready, rsp_valid,
               acc, alu_a, alu_s, rsp_y);
    end
  endtask

  task automatic check_init(input string tag);
    @(posedge clk); #1;
    checks++;
    if (alu_en !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_init en=%b rdy=%b want 1 0",
               tag, alu_en, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_en !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle en=%b rdy=%b want 0 1",
               tag, alu_en, cmd_ready);
    end
  endtask

  task automatic test_reset();
    en_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_vals");
    en_n = 1'b1;
    check_init("reset");
  endtask

  task automatic test_add();
    send(4'd0, 8'h05, 8'h03, 0, 8'h05,
         16'h0008, 0, 0, 8'h08, 3);
    recv(0);
  endtask

  task automatic test_sub_zero();
    send(4'd1, 8'h05, 8'h05, 0, 8'h05,
         16'h0000, 0, 0, 8'h00, 3);
    recv(0);
  endtask

  task automatic test_chain();
    send(4'd0, 8'h05, 8'h03, 0, 8'h05,
         16'h0008, 0, 0, 8'h08, 3);
    recv(0);
    send(4'd0, 8'hEE, 8'h02, 1, 8'h08,
         16'h000A, 0, 0, 8'h0A, 3);
    recv(0);
  endtask

  task automatic test_shift();
    send(4'd12, 8'h81, 8'h00, 0, 8'h81,
         16'h0002, 1, 0, 8'h02, 3);
    recv(0);
    send(4'd14, 8'h01, 8'h00, 0, 8'h01,
         16'h0080, 1, 0, 8'h80, 3);
    recv(0);
  endtask

  task automatic test_mul_upper();
    send(4'd4, 8'h10, 8'h20, 0, 8'h10,
         16'h0200, 0, 0, 8'h00, 3);
    recv(0);
    send(4'd4, 8'hFF, 8'hFF, 0, 8'hFF,
         16'hFE01, 0, 0, 8'h01, 3);
    recv(0);
  endtask

  task automatic test_div_zero();
    send(4'd5, 8'h33, 8'h00, 0, 8'h00,
         16'h0000, 0, 1, 8'h01, 0);
    checks++;
    if (alu_s !== 4'd4 || alu_a !== 8'hFF) begin
      errors++;
      $display("FAIL div0_pins s=%h a=%h want 4 ff",
               alu_s, alu_a);
    end
    recv(0);
    send(4'd5, 8'h20, 8'h05, 0, 8'h20,
         16'h0006, 0, 0, 8'h06, 3);
    recv(0);
  endtask

  task automatic test_back_to_back();
    send(4'd8, 8'hF0, 8'h3C, 0, 8'hF0,
         16'h00CC, 0, 0, 8'hCC, 3);
    recv(5);
    send(4'd3, 8'h00, 8'h00, 0, 8'h00,
         16'h00FF, 1, 0, 8'hFF, 3);
    recv(0);
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    cmd_op = 4'd0; cmd_a = 8'h11;
    cmd_b = 8'h22; cmd_use_acc = 0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    en_n = 1'b0;
    #1;
    check_reset_vals("midwait_reset");
    @(posedge clk); #1;
    en_n = 1'b1;
    check_init("midwait");
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midwait_no_rsp got 1 want 0");
    end
    send(4'd0, 8'h99, 8'h01, 1, 8'h00,
         16'h0001, 0, 0, 8'h01, 3);
    recv(0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d want 0",
               sb.size());
    end
  endtask

  initial begin
    en_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_zero();
    test_chain();
    test_shift();
    test_mul_upper();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
